regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the register address width (32 registers).
REQ-003 The block SHALL have parameter ZERO_LOCK, default 1; when 1, writes to address 0 are discarded.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 a_valid  input  1  requester A write request.
REQ-007 a_addr  input  ADDR_WIDTH  requester A target register.
REQ-008 a_data  input  DATA_WIDTH  requester A write data.
REQ-009 a_ready  output  1  requester A request accepted this cycle.
REQ-010 b_valid, b_addr, b_data, b_ready SHALL mirror REQ-006..REQ-009 for requester B.
REQ-011 wr_hold  input  1  register file cannot take a write; freezes output stage.
REQ-012 wr_en  output  1  registered write strobe to the address decoder and register file.
REQ-013 wr_addr  output  ADDR_WIDTH  registered write address, feeds the one-hot decoder.
REQ-014 wr_data  output  DATA_WIDTH  registered write data.
REQ-015 drop_cnt  output  8  count of discarded address-0 writes, saturating.

Function
REQ-016 A transfer SHALL occur on a requester when its valid and ready are both 1 at a rising clk edge.
REQ-017 a_ready and b_ready SHALL be combinational from valids, wr_hold and last_grant; at most one SHALL be 1 in any cycle.
REQ-018 With wr_hold=1, a_ready=b_ready=0 regardless of valids.
REQ-019 With wr_hold=0 and exactly one valid, that requester's ready SHALL be 1.
REQ-020 With wr_hold=0 and both valid, ready SHALL go to the requester not in last_grant (round-robin).
REQ-021 last_grant SHALL update to the winning requester on every transfer and hold otherwise.
REQ-022 On a transfer with address != 0 (or ZERO_LOCK=0), the next cycle SHALL show wr_en=1 with the accepted wr_addr/wr_data: one-cycle latency.
REQ-023 On a transfer with address == 0 and ZERO_LOCK=1, wr_en SHALL be 0 next cycle, wr_addr/wr_data SHALL hold, and drop_cnt SHALL increment.
REQ-024 drop_cnt SHALL saturate at 255 and never wrap.
REQ-025 With no transfer and wr_hold=0, wr_en SHALL be 0 next cycle; wr_addr/wr_data SHALL hold.
REQ-026 With wr_hold=1, wr_en, wr_addr and wr_data SHALL all hold their current values.
REQ-027 When both requesters target the same address in one cycle, only the winner SHALL be written; the loser SHALL keep valid and win the next non-held cycle.
REQ-028 A requester SHALL never wait more than one transfer while continuously valid and wr_hold=0 (no starvation).

Reset
REQ-029 While rst_n=0: wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0, last_grant=B, so A wins the first contention.
REQ-030 Reset assertion mid-transfer SHALL discard the pending write immediately; no write strobe SHALL follow reset release.
REQ-031 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 Reset, then A valid alone with addr=5, data=0xDEADBEEF -> a_ready=1; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF.
REQ-033 A and B both valid continuously for 4 cycles with addrs 1 and 2 -> grants A,B,A,B; wr_addr sequence 1,2,1,2 with wr_en=1 each cycle.
REQ-034 A write to addr 3 followed by wr_hold=1 for 3 cycles with both valid -> no ready; wr_en=1, wr_addr=3 held; after release, B is granted first.
REQ-035 A valid with addr=0 for 260 transfers (ZERO_LOCK=1) -> wr_en stays 0; drop_cnt reaches 255 and stays 255.
REQ-036 Assert rst_n=0 in the cycle after a transfer to addr 7 -> wr_en=0, wr_addr=0 immediately; no strobe after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter in front of a register file.
// Registers one accepted write per cycle; optionally discards writes to register 0.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_LOCK  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  wr_hold,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [7:0]            drop_cnt
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t                  last_grant;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    discard;

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!wr_hold) begin
            if (a_valid && b_valid) begin
                a_ready = (last_grant == GRANT_B);
                b_ready = (last_grant == GRANT_A);
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign sel_addr = b_ready ? b_addr : a_addr;
    assign sel_data = b_ready ? b_data : a_data;
    assign discard  = (ZERO_LOCK != 0) && (sel_addr == '0);

    // Readies are forced low under wr_hold, so a transfer implies the output stage is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_B;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            drop_cnt   <= '0;
        end else if (a_ready || b_ready) begin
            last_grant <= a_ready ? GRANT_A : GRANT_B;
            if (discard) begin
                wr_en <= 1'b0;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else begin
                wr_en   <= 1'b1;
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end else if (!wr_hold) begin
            wr_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a reference arbiter model pushes
// expected writes at each accepted transfer and they are popped when the strobe appears.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        wr_hold = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  drop_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // reference model state
    logic        mg;            // 0 = A won last, 1 = B won last
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [7:0]  exp_drop;
    logic [36:0] sb[$];

    regfile_write_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_LOCK (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .b_ready (b_ready),
        .wr_hold (wr_hold),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic exp_a_ready();
        return !wr_hold && a_valid && (!b_valid || mg == 1'b1);
    endfunction

    function automatic logic exp_b_ready();
        return !wr_hold && b_valid && (!a_valid || mg == 1'b0);
    endfunction

    task automatic model_reset();
        mg       = 1'b1;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_drop = '0;
        sb.delete();
    endtask

    // Predict the effect of the coming edge, advance to just after it, then
    // retire the scoreboard entry that the DUT should now be presenting.
    task automatic model_clock();
        logic        ea, eb;
        logic [4:0]  sa;
        logic [31:0] sd;
        logic [36:0] e;
        ea = exp_a_ready();
        eb = exp_b_ready();
        if (ea || eb) begin
            mg = eb;
            sa = ea ? a_addr : b_addr;
            sd = ea ? a_data : b_data;
            if (sa == 5'd0) begin
                exp_en = 1'b0;
                if (exp_drop != 8'd255) exp_drop = exp_drop + 8'd1;
            end else begin
                sb.push_back({sa, sd});
                exp_en = 1'b1;
            end
        end else if (!wr_hold) begin
            exp_en = 1'b0;
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e        = sb.pop_front();
            exp_addr = e[36:32];
            exp_data = e[31:0];
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        wr_hold = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1234_5678;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h8765_4321;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
        n_cmp++; if (wr_addr !== 5'd0) begin n_err++; $display("FAIL reset_wr_addr: got %0h expected 0", wr_addr); end
        n_cmp++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL reset_wr_data: got %0h expected 0", wr_data); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        a_valid = 1'b0;
        b_valid = 1'b0;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_single_a();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL single_a_ready: got %0b expected 1", a_ready); end
        n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL single_b_ready: got %0b expected 0", b_ready); end
        model_clock();
        a_valid = 1'b0;
        n_cmp++; if (wr_en !== exp_en) begin n_err++; $display("FAIL single_wr_en: got %0b expected %0b", wr_en, exp_en); end
        n_cmp++; if (wr_addr !== 5'd5) begin n_err++; $display("FAIL single_wr_addr: got %0d expected 5", wr_addr); end
        n_cmp++; if (wr_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wr_data: got %0h expected deadbeef", wr_data); end
        #1;
        model_clock();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL idle_wr_en: got %0b expected 0", wr_en); end
        n_cmp++; if (wr_addr !== exp_addr) begin n_err++; $display("FAIL idle_wr_addr_hold: got %0d expected %0d", wr_addr, exp_addr); end
    endtask

    task automatic test_round_robin();
        logic [4:0] want[4];
        want[0] = 5'd1; want[1] = 5'd2; want[2] = 5'd1; want[3] = 5'd2;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA000_0000;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (a_ready !== exp_a_ready() || b_ready !== exp_b_ready())
                begin n_err++; $display("FAIL rr_ready[%0d]: got a=%0b b=%0b expected a=%0b b=%0b", i, a_ready, b_ready, exp_a_ready(), exp_b_ready()); end
            model_clock();
            n_cmp++; if (wr_en !== 1'b1 || wr_addr !== want[i] || wr_data !== exp_data)
                begin n_err++; $display("FAIL rr_write[%0d]: got en=%0b addr=%0d data=%0h expected en=1 addr=%0d data=%0h", i, wr_en, wr_addr, wr_data, want[i], exp_data); end
            if (wr_addr == 5'd1) a_data = a_data + 32'd1;
            else                 b_data = b_data + 32'd1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_same_addr();
        do_reset();
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_AAAA;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_BBBB;
        model_clock();
        a_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b1 || wr_data !== 32'h0000_AAAA)
            begin n_err++; $display("FAIL same_addr_winner: got en=%0b data=%0h expected en=1 data=aaaa", wr_en, wr_data); end
        #1;
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL same_addr_loser_ready: got %0b expected 1", b_ready); end
        model_clock();
        b_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 32'h0000_BBBB)
            begin n_err++; $display("FAIL same_addr_loser: got en=%0b addr=%0d data=%0h expected en=1 addr=9 data=bbbb", wr_en, wr_addr, wr_data); end
    endtask

    task automatic test_hold();
        do_reset();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h3333_0003;
        model_clock();
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h6666_0006;
        wr_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
                begin n_err++; $display("FAIL hold_ready[%0d]: got a=%0b b=%0b expected a=0 b=0", i, a_ready, b_ready); end
            model_clock();
            n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'h3333_0003)
                begin n_err++; $display("FAIL hold_output[%0d]: got en=%0b addr=%0d data=%0h expected en=1 addr=3 data=33330003", i, wr_en, wr_addr, wr_data); end
        end
        wr_hold = 1'b0;
        #1;
        n_cmp++; if (b_ready !== 1'b1 || a_ready !== 1'b0)
            begin n_err++; $display("FAIL hold_release_grant: got a=%0b b=%0b expected a=0 b=1", a_ready, b_ready); end
        model_clock();
        a_valid = 1'b0;
        b_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd6 || wr_data !== exp_data)
            begin n_err++; $display("FAIL hold_release_write: got en=%0b addr=%0d data=%0h expected en=1 addr=6 data=%0h", wr_en, wr_addr, wr_data, exp_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            wr_hold = ($urandom_range(0, 3) == 0);
            a_valid = $urandom_range(0, 1);
            b_valid = $urandom_range(0, 1);
            a_addr  = 5'($urandom_range(0, 3));
            b_addr  = 5'($urandom_range(0, 3));
            a_data  = $urandom;
            b_data  = $urandom;
            #1;
            n_cmp++; if (a_ready !== exp_a_ready() || b_ready !== exp_b_ready())
                begin n_err++; $display("FAIL rand_ready[%0d]: got a=%0b b=%0b expected a=%0b b=%0b", i, a_ready, b_ready, exp_a_ready(), exp_b_ready()); end
            model_clock();
            n_cmp++; if (wr_en !== exp_en || wr_addr !== exp_addr || wr_data !== exp_data || drop_cnt !== exp_drop)
                begin n_err++; $display("FAIL rand_out[%0d]: got en=%0b addr=%0d data=%0h drop=%0d expected en=%0b addr=%0d data=%0h drop=%0d",
                    i, wr_en, wr_addr, wr_data, drop_cnt, exp_en, exp_addr, exp_data, exp_drop); end
        end
        wr_hold = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_zero_drop();
        int unsigned bad_en;
        int unsigned bad_cnt;
        bad_en  = 0;
        bad_cnt = 0;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd0;
        for (int i = 0; i < 260; i++) begin
            a_data = 32'(i);
            model_clock();
            if (wr_en !== 1'b0) bad_en++;
            if (drop_cnt !== exp_drop) bad_cnt++;
        end
        a_valid = 1'b0;
        n_cmp++; if (bad_en != 0) begin n_err++; $display("FAIL zero_wr_en: got %0d strobing cycles expected 0", bad_en); end
        n_cmp++; if (bad_cnt != 0) begin n_err++; $display("FAIL zero_drop_track: got %0d count mismatches expected 0", bad_cnt); end
        n_cmp++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL zero_drop_sat: got %0d expected 255", drop_cnt); end
        n_cmp++; if (wr_addr !== 5'd0 || wr_data !== 32'd0)
            begin n_err++; $display("FAIL zero_hold_out: got addr=%0d data=%0h expected addr=0 data=0", wr_addr, wr_data); end
    endtask

    task automatic test_reset_mid();
        int unsigned strobes;
        strobes = 0;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h7777_7777;
        model_clock();
        a_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd7)
            begin n_err++; $display("FAIL mid_pre_write: got en=%0b addr=%0d expected en=1 addr=7", wr_en, wr_addr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0)
            begin n_err++; $display("FAIL mid_async_clear: got en=%0b addr=%0d data=%0h expected en=0 addr=0 data=0", wr_en, wr_addr, wr_data); end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            model_clock();
            if (wr_en !== 1'b0) strobes++;
        end
        n_cmp++; if (strobes != 0) begin n_err++; $display("FAIL mid_no_strobe: got %0d strobes expected 0", strobes); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_a();
        test_round_robin();
        test_same_addr();
        test_hold();
        test_random();
        test_zero_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
